truth_table_sweeper: RTL and testbench

Sequential test harness stage that wraps a 3-input combinational logic gate (e.g. the 0xB4 function).
- Upstream role: drives the gate's inputs through all 2^N_IN combinations.
- Downstream role: samples the gate's output after a settle window and assembles the measured truth-table word.
- Compares the word against an expected hex code (Cello convention) and reports match/done to a controller.

---
 rtl/sweeper_pkg.sv | 32 +++
 rtl/sweep_sync2.sv | 23 ++
 rtl/truth_table_sweeper.sv | 134 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: state encoding, width helpers
// and common 3-input truth-table codes.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned tt_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Truth-table codes, combination 000 in the MSB.
    localparam logic [7:0] WOLF_B4  = 8'hB4;
    localparam logic [7:0] WOLF_A4  = 8'hA4;
    localparam logic [7:0] WOLF_96  = 8'h96;
    localparam logic [7:0] WOLF_E8  = 8'hE8;
    localparam logic [7:0] WOLF_80  = 8'h80;
    localparam logic [7:0] WOLF_FE  = 8'hFE;

endpackage

// File: rtl/sweep_sync2.sv
// Two-flop synchronizer for the gate output when it is not synchronous to clk.
module sweep_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a combinational gate through every input combination and assembles its truth table.
// Optional `SWEEP_SYNC_EN: synchronize dut_out through sweep_sync2 before sampling.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned          N_IN          = 3,
    parameter int unsigned          SETTLE_CYCLES = 4,
    parameter logic [tt_w(N_IN)-1:0] EXPECTED     = WOLF_B4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       in_vec,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [tt_w(N_IN)-1:0] table_out,
    output logic                  valid,
    output logic                  match
);

    localparam int unsigned TW = tt_w(N_IN);
    localparam int unsigned IW = N_IN + 1;
    localparam int unsigned CW = clog2(SETTLE_CYCLES) + 1;

    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(TW - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    logic sample_bit;

`ifdef SWEEP_SYNC_EN
    // Two synchronizer stages plus one settle cycle before the sample is trustworthy.
    if (SETTLE_CYCLES < 3) begin : g_bad_sync_settle
        $error("SETTLE_CYCLES must be at least 3 with SWEEP_SYNC_EN");
    end

    sweep_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dut_out),
        .q_o   (sample_bit)
    );
`else
    assign sample_bit = dut_out;
`endif

    sweep_state_e    state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   shadow_q, shadow_d;
    logic [TW-1:0]   table_q, table_d;
    logic            valid_q, valid_d;
    logic            match_q, match_d;
    logic [N_IN-1:0] bit_pos;

    // Combination idx lands at bit TW-1-idx, i.e. the bitwise complement of idx.
    assign bit_pos = ~idx_q[N_IN-1:0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        table_d  = table_q;
        valid_d  = valid_q;
        match_d  = match_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    cnt_d    = CNT_RELOAD;
                    shadow_d = '0;
                    valid_d  = 1'b0;
                    match_d  = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shadow_d[bit_pos] = sample_bit;
                    if (idx_q == IDX_LAST) begin
                        // Publish together with the final sample so results coincide with done.
                        state_d = DONE;
                        table_d = shadow_d;
                        valid_d = 1'b1;
                        match_d = (shadow_d == EXPECTED);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = CNT_RELOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            table_q  <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            table_q  <= table_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign in_vec    = busy ? idx_q[N_IN-1:0] : '0;
    assign table_out = table_q;
    assign valid     = valid_q;
    assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a behavioural gate model driven by in_vec.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] in_vec;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       valid;
    logic       match;

    logic [7:0] tt_model;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         first_done;
    int         n_done;

    always #5 clk = ~clk;

    // Gate model: combination 000 reads the MSB of the code.
    assign dut_out = tt_model[3'd7 - in_vec];

    truth_table_sweeper #(
        .N_IN          (3),
        .SETTLE_CYCLES (4),
        .EXPECTED      (8'hB4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_vec    (in_vec),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .valid     (valid),
        .match     (match)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse is sampled at edge 0; loop index cyc is the cycle after edge cyc-1.
    task automatic run_sweep(input int abort_at, input int restart_a, input int restart_b,
                             input bit chk_steps, output int fd, output int nd);
        start = 1'b1;
        tick();
        start = 1'b0;
        fd = 0;
        nd = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                nd++;
                if (fd == 0) fd = cyc;
            end
            if (chk_steps) begin
                if (cyc == 1)  check_eq("in_vec_c1", in_vec, 0);
                if (cyc == 5)  check_eq("in_vec_c5", in_vec, 1);
                if (cyc == 16) check_eq("in_vec_c16", in_vec, 3);
                if (cyc == 32) check_eq("in_vec_c32", in_vec, 7);
                if (cyc == 32) check_eq("busy_c32", busy, 1);
                if (cyc == 33) check_eq("busy_c33", busy, 0);
                if (cyc == 33) check_eq("valid_at_done", valid, 1);
            end
            if (cyc == abort_at + 1) check_eq("busy_after_abort", busy, 0);
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == restart_a || cyc == restart_b) start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        tt_model = 8'hB4;
        tick();
        tick();
        check_eq("rst_in_vec", in_vec, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_table", table_out, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_match", match, 0);
        rst_n = 1'b1;
        tick();

        // Nominal 0xB4 sweep
        run_sweep(-1, -1, -1, 1'b1, first_done, n_done);
        check_eq("b4_done_cycle", first_done, 33);
        check_eq("b4_done_count", n_done, 1);
        check_eq("b4_table", table_out, 8'hB4);
        check_eq("b4_match", match, 1);
        check_eq("b4_valid", valid, 1);

        // Abort mid-sweep keeps prior table, clears valid
        run_sweep(10, -1, -1, 1'b0, first_done, n_done);
        check_eq("abort_done_count", n_done, 0);
        check_eq("abort_valid", valid, 0);
        check_eq("abort_table", table_out, 8'hB4);
        check_eq("abort_match", match, 0);

        // Start during RUN is ignored
        run_sweep(-1, 5, 20, 1'b0, first_done, n_done);
        check_eq("restart_done_cycle", first_done, 33);
        check_eq("restart_done_count", n_done, 1);
        check_eq("restart_table", table_out, 8'hB4);

        // Row 011 flipped
        tt_model = 8'hA4;
        run_sweep(-1, -1, -1, 1'b0, first_done, n_done);
        check_eq("a4_done_cycle", first_done, 33);
        check_eq("a4_table", table_out, 8'hA4);
        check_eq("a4_match", match, 0);
        check_eq("a4_valid", valid, 1);

        // Abort together with start in IDLE drops the start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("idle_abort_busy", busy, 0);
        check_eq("idle_abort_valid", valid, 1);
        tick();

        // Asynchronous reset mid-sweep
        tt_model = 8'hB4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check_eq("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_vec", in_vec, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_table", table_out, 0);
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_match", match, 0);
        #2;
        rst_n = 1'b1;
        tick();
        run_sweep(-1, -1, -1, 1'b0, first_done, n_done);
        check_eq("post_rst_done_cycle", first_done, 33);
        check_eq("post_rst_table", table_out, 8'hB4);
        check_eq("post_rst_match", match, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
